// File: rtl/mem_access_unit.sv
// mem_access_unit -- MEM-stage data-memory access unit feeding the MEM/WB register.
//
// Takes address, store data and controls from EX/MEM.
// Runs one req/ready transaction on the data bus for each load or store.
// Aligns and extends the load data.
// Presents readData/aluResult/rd/memToReg/regWrite to MEM/WB.
// While a transaction is outstanding, stall holds the upstream pipeline and
// the WB controls are forced low, so MEM/WB samples bubbles.
//
// Parameters:
//   TIMEOUT_CYCLES  max BUSY cycles without dmemReady before abort (1..255)
// Compile-time option:
//   MEM_MISALIGN_TRAP_EN  when defined, a misaligned access raises misalignErr
//                         and never reaches the bus. When undefined, the
//                         offending low address bits are forced to zero.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   valid..regWrite       EX/MEM inputs (held by upstream while stall=1)
//   stall                 pipeline hold request
//   readDataOut..regWriteOut  MEM/WB outputs
//   busError              one-cycle pulse on a timed-out transaction
//   misalignErr           misaligned-access flag (trap build only)
//   dmemReq..dmemBe       data-bus request side (registered)
//   dmemReady, dmemRdata  data-bus response side
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic [31:0] aluResult,
  input  logic [31:0] writeData,
  input  logic [4:0]  rd,
  input  logic [2:0]  funct3,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic        memToReg,
  input  logic        regWrite,
  output logic        stall,
  output logic [31:0] readDataOut,
  output logic [31:0] aluResultOut,
  output logic [4:0]  rdOut,
  output logic        memToRegOut,
  output logic        regWriteOut,
  output logic        busError,
  output logic        misalignErr,
  output logic        dmemReq,
  output logic        dmemWe,
  output logic [31:0] dmemAddr,
  output logic [31:0] dmemWdata,
  output logic [3:0]  dmemBe,
  input  logic        dmemReady,
  input  logic [31:0] dmemRdata
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state;
  logic [31:0] aluQ;
  logic [4:0]  rdQ;
  logic        memToRegQ;
  logic        regWriteQ;
  logic        memReadQ;
  logic [2:0]  funct3Q;
  logic [1:0]  offQ;
  logic [31:0] dataQ;
  logic [7:0]  cnt;

  logic        memOp;
  logic        trap;
  logic [1:0]  reqOff;
  logic [3:0]  reqBe;
  logic [31:0] reqWdata;
  logic [31:0] lane;
  logic [31:0] loadExt;

  assign memOp = valid & (memRead | memWrite);

`ifdef MEM_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = ((funct3[1:0] == 2'b01) & aluResult[0]) |
                      (funct3[1] & (aluResult[1:0] != 2'b00));
  assign trap = memOp & misaligned;
`else
  assign trap = 1'b0;
`endif

  // Byte offset actually used on the bus.
  // Halfwords keep only a[1] and words always use lane 0,
  // which also gives the forced alignment of the non-trap build.
  always_comb begin
    reqOff   = 2'b00;
    reqBe    = 4'b1111;
    reqWdata = writeData;
    case (funct3[1:0])
      2'b00: begin
        reqOff   = aluResult[1:0];
        reqBe    = 4'b0001 << aluResult[1:0];
        reqWdata = {4{writeData[7:0]}};
      end
      2'b01: begin
        reqOff   = {aluResult[1], 1'b0};
        reqBe    = 4'b0011 << {aluResult[1], 1'b0};
        reqWdata = {2{writeData[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    lane    = dmemRdata >> {offQ, 3'b000};
    loadExt = lane;
    case (funct3Q[1:0])
      2'b00:   loadExt = funct3Q[2] ? {24'b0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
      2'b01:   loadExt = funct3Q[2] ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: loadExt = lane;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      dmemReq   <= 1'b0;
      dmemWe    <= 1'b0;
      dmemAddr  <= '0;
      dmemWdata <= '0;
      dmemBe    <= '0;
      aluQ      <= '0;
      rdQ       <= '0;
      memToRegQ <= 1'b0;
      regWriteQ <= 1'b0;
      memReadQ  <= 1'b0;
      funct3Q   <= '0;
      offQ      <= '0;
      dataQ     <= '0;
      cnt       <= '0;
      busError  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          busError <= 1'b0;
          if (memOp && !trap) begin
            aluQ      <= aluResult;
            rdQ       <= rd;
            memToRegQ <= memToReg;
            regWriteQ <= regWrite;
            memReadQ  <= memRead;
            funct3Q   <= funct3;
            offQ      <= reqOff;
            dmemReq   <= 1'b1;
            dmemWe    <= memWrite;
            dmemAddr  <= {aluResult[31:2], 2'b00};
            dmemWdata <= reqWdata;
            dmemBe    <= reqBe;
            cnt       <= '0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          // When ready and timeout coincide, ready takes priority.
          if (dmemReady) begin
            dmemReq <= 1'b0;
            dmemWe  <= 1'b0;
            dataQ   <= memReadQ ? loadExt : '0;
            state   <= RESP;
          end else if (cnt == 8'(TIMEOUT_CYCLES - 1)) begin
            dmemReq  <= 1'b0;
            dmemWe   <= 1'b0;
            dataQ    <= '0;
            busError <= 1'b1;
            state    <= RESP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP: begin
          busError <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // busError is high only in a timed-out RESP, so it doubles as the abort flag.
  always_comb begin
    stall        = 1'b0;
    readDataOut  = '0;
    aluResultOut = aluResult;
    rdOut        = rd;
    memToRegOut  = memToReg;
    regWriteOut  = regWrite;
    misalignErr  = 1'b0;
    case (state)
      IDLE: begin
        if (trap) begin
          misalignErr = 1'b1;
          regWriteOut = 1'b0;
        end else if (memOp) begin
          stall       = 1'b1;
          regWriteOut = 1'b0;
          memToRegOut = 1'b0;
        end
      end
      BUSY: begin
        stall       = 1'b1;
        regWriteOut = 1'b0;
        memToRegOut = 1'b0;
      end
      RESP: begin
        aluResultOut = aluQ;
        rdOut        = rdQ;
        memToRegOut  = memToRegQ;
        regWriteOut  = regWriteQ & ~busError;
        readDataOut  = dataQ;
      end
      default: ;
    endcase
  end

endmodule
